// File: rtl/waveshaper_mv_pkg.sv
// Shared types and constants for the multi-voice waveshaper.
package waveshaper_mv_pkg;

    typedef enum logic [2:0] {
        MODE_OFF      = 3'd0,
        MODE_SQUARE   = 3'd1,
        MODE_SAW      = 3'd2,
        MODE_TRIANGLE = 3'd3,
        MODE_NOISE    = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'h0001;

    // Right-shifting Galois step, taps 16,14,13,11.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    function automatic int unsigned voice_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/waveshaper_mv_if.sv
// Control/config inputs and mix outputs of the multi-voice waveshaper.
interface waveshaper_mv_if #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned SAMPLE_W   = 8,
    parameter int unsigned PHASE_W    = 24,
    parameter int unsigned LEVEL_W    = 8
);
    localparam int unsigned VOICE_W = waveshaper_mv_pkg::voice_w(NUM_VOICES);

    logic                sample_tick_i;
    logic                cfg_we_i;
    logic [VOICE_W-1:0]  cfg_voice_i;
    logic [2:0]          cfg_mode_i;
    logic [PHASE_W-1:0]  cfg_step_i;
    logic [SAMPLE_W-1:0] cfg_pw_i;
    logic [LEVEL_W-1:0]  cfg_level_i;
    logic [SAMPLE_W-1:0] mix_o;
    logic                mix_valid_o;
    logic                sat_o;
    logic                busy_o;
    logic                overrun_o;

    modport master (
        output sample_tick_i, cfg_we_i, cfg_voice_i, cfg_mode_i, cfg_step_i,
               cfg_pw_i, cfg_level_i,
        input  mix_o, mix_valid_o, sat_o, busy_o, overrun_o
    );

    modport slave (
        input  sample_tick_i, cfg_we_i, cfg_voice_i, cfg_mode_i, cfg_step_i,
               cfg_pw_i, cfg_level_i,
        output mix_o, mix_valid_o, sat_o, busy_o, overrun_o
    );

endinterface

// File: rtl/waveshaper_mv_voice.sv
// Shared per-voice shaper: phase sample + config -> level-scaled sample.
module waveshaper_mv_voice
    import waveshaper_mv_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 8,
    parameter int unsigned LEVEL_W  = 8
) (
    input  logic [SAMPLE_W-1:0] t,
    input  logic [2:0]          mode,
    input  logic [SAMPLE_W-1:0] pw,
    input  logic [LEVEL_W-1:0]  level,
    input  logic [SAMPLE_W-1:0] noise,
    output logic [SAMPLE_W-1:0] scaled_c
);
    localparam int unsigned PROD_W = SAMPLE_W + LEVEL_W;

    logic [SAMPLE_W-1:0] shape_c;
    logic [SAMPLE_W-1:0] tri_c;
    logic [PROD_W-1:0]   prod_c;

    // Rising half doubles t, falling half mirrors it.
    assign tri_c = t[SAMPLE_W-1] ? ~{t[SAMPLE_W-2:0], 1'b0} : {t[SAMPLE_W-2:0], 1'b0};

    always_comb begin
        shape_c = '0;
        case (mode)
            MODE_SQUARE:   shape_c = (t < pw) ? '1 : '0;
            MODE_SAW:      shape_c = t;
            MODE_TRIANGLE: shape_c = tri_c;
            MODE_NOISE:    shape_c = noise;
            default:       shape_c = '0;
        endcase
    end

    assign prod_c   = PROD_W'(shape_c) * PROD_W'(level);
    assign scaled_c = SAMPLE_W'(prod_c >> LEVEL_W);

endmodule

// File: rtl/waveshaper_mv.sv
// Time-multiplexed multi-voice waveshaper: one voice per cycle summed into a saturated mix.
module waveshaper_mv
    import waveshaper_mv_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned SAMPLE_W   = 8,
    parameter int unsigned PHASE_W    = 24,
    parameter int unsigned LEVEL_W    = 8
) (
    input  logic          clk,
    input  logic          Rst_i,
    waveshaper_mv_if.slave bus
);
    localparam int unsigned VOICE_W = voice_w(NUM_VOICES);
    localparam int unsigned ACC_W   = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam logic [SAMPLE_W-1:0] MAX_S      = '1;
    localparam logic [VOICE_W-1:0]  LAST_VOICE = VOICE_W'(NUM_VOICES - 1);

    typedef struct packed {
        logic [2:0]          mode;
        logic [PHASE_W-1:0]  step;
        logic [SAMPLE_W-1:0] pw;
        logic [LEVEL_W-1:0]  level;
    } cfg_t;

    cfg_t                cfg_q   [NUM_VOICES];
    logic [PHASE_W-1:0]  phase_q [NUM_VOICES];

    state_e              state_q, state_n;
    logic [VOICE_W-1:0]  voice_q, voice_d;
    logic [ACC_W-1:0]    acc_q, acc_d, acc_sum_c;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [SAMPLE_W-1:0] mix_d;
    logic                sat_d, mix_valid_d, busy_d, overrun_d;

    cfg_t                cur_c;
    logic [SAMPLE_W-1:0] t_c, scaled_c;
    logic                last_c, cfg_hit_c;

    assign cur_c     = cfg_q[voice_q];
    assign t_c       = phase_q[voice_q][PHASE_W-1 -: SAMPLE_W];
    assign last_c    = (voice_q == LAST_VOICE);
    assign acc_sum_c = acc_q + ACC_W'(scaled_c);
    assign cfg_hit_c = bus.cfg_we_i && (32'(bus.cfg_voice_i) < NUM_VOICES);

    waveshaper_mv_voice #(
        .SAMPLE_W (SAMPLE_W),
        .LEVEL_W  (LEVEL_W)
    ) u_voice (
        .t        (t_c),
        .mode     (cur_c.mode),
        .pw       (cur_c.pw),
        .level    (cur_c.level),
        .noise    (lfsr_q[SAMPLE_W-1:0]),
        .scaled_c (scaled_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (Rst_i) state_q <= IDLE;
        else       state_q <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (bus.sample_tick_i) state_n = RUN;
            RUN:     if (last_c) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output/datapath next values; the mix lands on the last-voice edge so the
    // valid pulse coincides with the DONE cycle.
    always_comb begin
        voice_d     = voice_q;
        acc_d       = acc_q;
        lfsr_d      = lfsr_q;
        mix_d       = bus.mix_o;
        sat_d       = bus.sat_o;
        mix_valid_d = 1'b0;
        busy_d      = (state_n != IDLE);
        overrun_d   = bus.sample_tick_i && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.sample_tick_i) begin
                    voice_d = '0;
                    acc_d   = '0;
                end
            end
            RUN: begin
                acc_d   = acc_sum_c;
                voice_d = voice_q + VOICE_W'(1);
                if (last_c) begin
                    voice_d     = '0;
                    sat_d       = (acc_sum_c > ACC_W'(MAX_S));
                    mix_d       = sat_d ? MAX_S : acc_sum_c[SAMPLE_W-1:0];
                    mix_valid_d = 1'b1;
                end
            end
            DONE:    lfsr_d = lfsr_next(lfsr_q);
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (Rst_i) begin
            voice_q         <= '0;
            acc_q           <= '0;
            lfsr_q          <= LFSR_SEED;
            bus.mix_o       <= '0;
            bus.sat_o       <= 1'b0;
            bus.mix_valid_o <= 1'b0;
            bus.busy_o      <= 1'b0;
            bus.overrun_o   <= 1'b0;
        end else begin
            voice_q         <= voice_d;
            acc_q           <= acc_d;
            lfsr_q          <= lfsr_d;
            bus.mix_o       <= mix_d;
            bus.sat_o       <= sat_d;
            bus.mix_valid_o <= mix_valid_d;
            bus.busy_o      <= busy_d;
            bus.overrun_o   <= overrun_d;
        end
    end

    // Voice state: the processed voice reads old config/phase, writes land at the edge.
    always_ff @(posedge clk) begin
        if (Rst_i) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
                cfg_q[i]   <= '0;
            end
        end else begin
            if (state_q == RUN) phase_q[voice_q] <= phase_q[voice_q] + cur_c.step;
            if (cfg_hit_c) begin
                cfg_q[bus.cfg_voice_i] <= '{mode:  bus.cfg_mode_i,
                                            step:  bus.cfg_step_i,
                                            pw:    bus.cfg_pw_i,
                                            level: bus.cfg_level_i};
            end
        end
    end

endmodule
